pixel_compositor: RTL and testbench
===================================

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 The module SHALL have parameter NUM_LAYERS, default 2: number of sprite layers composited (1..4).
REQ-002 The module SHALL have parameter TRANSPARENT, default 4'd8: palette index treated as see-through.
REQ-003 CLK  input  1  pixel clock; the design SHALL use only this clock.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 layer_px  input  4*NUM_LAYERS  per-layer palette indices from the sprite ROM stages; layer 0 occupies bits [3:0] and has the highest priority.
REQ-006 bg_index  input  4  background palette index.
REQ-007 video_on, hsync, vsync  input  1 each  timing from the VGA counter, aligned with layer_px.
REQ-008 vblank  input  1  high during vertical blanking.
REQ-009 wr_valid  input  1  palette write request.
REQ-010 wr_addr  input  4  palette write address.
REQ-011 wr_data  input  12  palette write data, 4:4:4 RGB.
REQ-012 wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-013 rgb  output  12  pixel colour.
REQ-014 hsync_o, vsync_o  output  1 each  timing delayed to match rgb.

Function
REQ-015 Stage 1 SHALL register the index of the lowest-numbered layer whose value is not TRANSPARENT; if all layers are TRANSPARENT, it SHALL register bg_index.
REQ-016 Stage 2 SHALL register rgb = palette[stage-1 index] when the delayed video_on is 1, and 12'h000 otherwise.
REQ-017 The latency from inputs to rgb, hsync_o and vsync_o SHALL be exactly 2 cycles.
REQ-018 The sync delay path SHALL be independent of palette write activity.
REQ-019 The palette SHALL be 16 entries of 12 bits.
REQ-020 Write handshake: a one-entry pending buffer SHALL capture wr_addr and wr_data on acceptance.
REQ-021 wr_ready SHALL equal NOT pending.
REQ-022 A pending write SHALL commit to the palette on the first cycle with vblank=1, and pending SHALL clear on that same cycle.
REQ-023 A write accepted while vblank=1 SHALL commit on the next cycle if vblank is still 1.
REQ-024 wr_ready SHALL rise the cycle after commit, so back-to-back writes during vblank complete at one per 2 cycles.
REQ-025 If a palette read and a commit hit the same address in the same cycle, the read SHALL return the old value.
REQ-026 bg_index equal to TRANSPARENT SHALL be looked up normally and SHALL NOT be special-cased.

Reset
REQ-027 While RST=1 at a CLK edge: rgb=0, hsync_o=0, vsync_o=0, pipeline indices=TRANSPARENT, pending=0, and wr_ready=1 in the cycle after.
REQ-028 Reset SHALL reload every palette entry from DEFAULT_PALETTE.
REQ-029 A pending write SHALL be discarded if reset occurs before it commits.

Configuration
REQ-030 With PIXEL_COMPOSITOR_PALETTE_WR_EN defined, the write buffer and the writable palette SHALL be present as in REQ-019..REQ-025.
REQ-031 Without PIXEL_COMPOSITOR_PALETTE_WR_EN, the palette SHALL be constant DEFAULT_PALETTE, wr_ready SHALL be tied to 0, and wr_* inputs SHALL be ignored; ports SHALL be unchanged.

Structure
REQ-032 Shared package vga_pkg SHALL hold RGB_W=12, IDX_W=4, TRANSPARENT_IDX=4'd8, and DEFAULT_PALETTE (16x12, with entry 2=12'hF00, entry 5=12'h0F0, and entry 8=12'h000).
REQ-033 One sub-module, pixel_palette, SHALL implement the 16x12 palette register file with its reset-load and commit port.

Verification
REQ-034 NUM_LAYERS=2, layer_px={4'd5,4'd2}, video_on=1 -> rgb=12'hF00 exactly 2 cycles later.
REQ-035 layer_px={4'd8,4'd8}, bg_index=4'd5 -> rgb=12'h0F0; then video_on=0 -> rgb=12'h000 2 cycles later; hsync/vsync pulses SHALL appear on hsync_o/vsync_o delayed by exactly 2 cycles.
REQ-036 With the macro defined, vblank=0, write addr 2 data 12'h00F -> wr_ready=0 and layer index 2 still gives 12'hF00; raise vblank -> commit; next frame index 2 gives 12'h00F and wr_ready=1.
REQ-037 During vblank, with a held read of address 2 and a commit to address 2 of 12'hABC in the same cycle -> that output shows the old value and the next cycle shows 12'hABC.
REQ-038 With a pending write, assert RST -> palette entry unchanged (default), pending cleared, and wr_ready=1 after reset.
REQ-039 With the macro undefined, wr_valid=1 for 100 cycles with vblank=1 -> wr_ready stays 0 and the palette matches DEFAULT_PALETTE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: colour/index widths, transparent index and the default palette.
package vga_pkg;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned PAL_DEPTH = 16;

  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'd8;

  // Entry 0 first; 4:4:4 RGB.
  localparam logic [0:PAL_DEPTH-1][RGB_W-1:0] DEFAULT_PALETTE = '{
    12'h000, 12'h00A, 12'hF00, 12'h0AA,
    12'hA00, 12'h0F0, 12'hA50, 12'hAAA,
    12'h000, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

endpackage

// File: rtl/pixel_palette.sv
// 16x12 palette register file: reloads DEFAULT_PALETTE on reset, one commit (write) port and
// one asynchronous read port. A read and a commit to the same entry in one cycle see the old
// value because the read is combinational from the current register contents.
module pixel_palette
  import vga_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             commit,
  input  logic [IDX_W-1:0] commit_addr,
  input  logic [RGB_W-1:0] commit_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [RGB_W-1:0] rd_data
);

  logic [RGB_W-1:0] pal_q [PAL_DEPTH];

  // Palette storage: reset reload, otherwise single-entry commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) begin
        pal_q[i] <= DEFAULT_PALETTE[i];
      end
    end else if (commit) begin
      pal_q[commit_addr] <= commit_data;
    end
  end

  assign rd_data = pal_q[rd_addr];

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage sprite compositor: stage 1 picks the highest-priority opaque layer index (or the
// background), stage 2 looks it up in the palette. Sync signals ride a parallel 2-deep delay.
// Optional feature macro: PIXEL_COMPOSITOR_PALETTE_WR_EN enables the writable palette and its
// vblank-committed write buffer; without it the palette is the constant default.
module pixel_compositor
  import vga_pkg::*;
#(
  parameter int unsigned      NUM_LAYERS  = 2,
  parameter logic [IDX_W-1:0] TRANSPARENT = TRANSPARENT_IDX
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [IDX_W*NUM_LAYERS-1:0] layer_px,
  input  logic [IDX_W-1:0]            bg_index,
  input  logic                        video_on,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        vblank,
  input  logic                        wr_valid,
  input  logic [IDX_W-1:0]            wr_addr,
  input  logic [RGB_W-1:0]            wr_data,
  output logic                        wr_ready,
  output logic [RGB_W-1:0]            rgb,
  output logic                        hsync_o,
  output logic                        vsync_o
);

  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] idx1_q;
  logic             von1_q, hs1_q, vs1_q;
  logic [RGB_W-1:0] rgb_q;
  logic             hs2_q, vs2_q;
  logic [RGB_W-1:0] pal_rd;

  // Priority select: scan from the lowest priority up so layer 0 overrides everything.
  always_comb begin
    sel_idx = bg_index;
    for (int l = int'(NUM_LAYERS) - 1; l >= 0; l--) begin
      if (layer_px[l*IDX_W +: IDX_W] != TRANSPARENT) begin
        sel_idx = layer_px[l*IDX_W +: IDX_W];
      end
    end
  end

  // Stage 1: selected index plus delayed timing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx1_q <= TRANSPARENT;
      von1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
    end else begin
      idx1_q <= sel_idx;
      von1_q <= video_on;
      hs1_q  <= hsync;
      vs1_q  <= vsync;
    end
  end

  // Stage 2: palette lookup, blanked outside the active video area.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rgb_q <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      rgb_q <= von1_q ? pal_rd : '0;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign rgb     = rgb_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;

`ifdef PIXEL_COMPOSITOR_PALETTE_WR_EN
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] waddr_q, waddr_d;
  logic [RGB_W-1:0] wdata_q, wdata_d;
  logic             commit;

  // Write buffer: accept when empty, commit on the first vblank cycle while pending.
  always_comb begin
    pend_d  = pend_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    commit  = pend_q & vblank;
    if (commit) begin
      pend_d = 1'b0;
    end else if (wr_valid && !pend_q) begin
      pend_d  = 1'b1;
      waddr_d = wr_addr;
      wdata_d = wr_data;
    end
  end

  // Write buffer state; reset discards any uncommitted write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wr_ready = ~pend_q;

  pixel_palette u_palette (
    .CLK         (CLK),
    .RST         (RST),
    .commit      (commit),
    .commit_addr (waddr_q),
    .commit_data (wdata_q),
    .rd_addr     (idx1_q),
    .rd_data     (pal_rd)
  );
`else
  logic unused_wr;

  assign pal_rd    = DEFAULT_PALETTE[idx1_q];
  assign wr_ready  = 1'b0;
  assign unused_wr = ^{wr_valid, wr_addr, wr_data, vblank};
`endif

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor (NUM_LAYERS=2). Covers both builds of the
// PIXEL_COMPOSITOR_PALETTE_WR_EN feature.
module tb_pixel_compositor;

  localparam int NL = 2;

  localparam logic [11:0] DEF_PAL [16] = '{
    12'h000, 12'h00A, 12'hF00, 12'h0AA,
    12'hA00, 12'h0F0, 12'hA50, 12'hAAA,
    12'h000, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

`ifdef PIXEL_COMPOSITOR_PALETTE_WR_EN
  localparam logic EXP_READY = 1'b1;
`else
  localparam logic EXP_READY = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  layer_px;
  logic [3:0]  bg_index;
  logic        video_on, hsync, vsync, vblank;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] ref_pal [16];
  logic [13:0] exp_q [$];

  pixel_compositor #(
    .NUM_LAYERS  (NL),
    .TRANSPARENT (4'd8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .layer_px (layer_px),
    .bg_index (bg_index),
    .video_on (video_on),
    .hsync    (hsync),
    .vsync    (vsync),
    .vblank   (vblank),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rgb      (rgb),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    layer_px = 8'h88;
    bg_index = 4'd0;
    video_on = 1'b0;
    hsync    = 1'b0;
    vsync    = 1'b0;
    vblank   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 12'h000;
  endtask

  // Reference: first non-transparent layer from layer 0 upward, else background.
  function automatic logic [3:0] pick(input logic [7:0] lp, input logic [3:0] bg);
    for (int l = 0; l < NL; l++) begin
      if (lp[l*4 +: 4] != 4'd8) return lp[l*4 +: 4];
    end
    return bg;
  endfunction

  function automatic logic [13:0] model_out(input logic von, input logic [7:0] lp,
                                            input logic [3:0] bg, input logic hs,
                                            input logic vs);
    logic [11:0] c;
    c = von ? ref_pal[pick(lp, bg)] : 12'h000;
    return {hs, vs, c};
  endfunction

  task automatic test_reset();
    idle();
    layer_px = 8'h25;
    video_on = 1'b1;
    hsync    = 1'b1;
    vsync    = 1'b1;
    RST      = 1'b1;
    step();
    step();
    n_checks++;
    if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb);
    else n_pass++;
    n_checks++;
    if (hsync_o !== 1'b0) $display("FAIL reset_hsync: got %b want 0", hsync_o);
    else n_pass++;
    n_checks++;
    if (vsync_o !== 1'b0) $display("FAIL reset_vsync: got %b want 0", vsync_o);
    else n_pass++;
    RST = 1'b0;
    idle();
    step();
    n_checks++;
    if (wr_ready !== EXP_READY) $display("FAIL reset_ready: got %b want %b", wr_ready, EXP_READY);
    else n_pass++;
  endtask

  task automatic test_priority();
    idle();
    step();
    step();
    layer_px = {4'd5, 4'd2};
    video_on = 1'b1;
    step();
    n_checks++;
    if (rgb !== 12'h000) $display("FAIL prio_latency1: got %h want 000", rgb);
    else n_pass++;
    step();
    n_checks++;
    if (rgb !== 12'hF00) $display("FAIL prio_layer0: got %h want F00", rgb);
    else n_pass++;
  endtask

  task automatic test_background();
    idle();
    layer_px = 8'h88;
    bg_index = 4'd5;
    video_on = 1'b1;
    step();
    step();
    n_checks++;
    if (rgb !== 12'h0F0) $display("FAIL bg_lookup: got %h want 0F0", rgb);
    else n_pass++;
    video_on = 1'b0;
    step();
    n_checks++;
    if (rgb !== 12'h0F0) $display("FAIL blank_latency1: got %h want 0F0", rgb);
    else n_pass++;
    step();
    n_checks++;
    if (rgb !== 12'h000) $display("FAIL blank: got %h want 000", rgb);
    else n_pass++;
  endtask

  task automatic test_sync_delay();
    idle();
    step();
    step();
    hsync = 1'b1;
    step();
    hsync = 1'b0;
    vsync = 1'b1;
    n_checks++;
    if (hsync_o !== 1'b0) $display("FAIL hs_early: got %b want 0", hsync_o);
    else n_pass++;
    step();
    vsync = 1'b0;
    n_checks++;
    if ({hsync_o, vsync_o} !== 2'b10) $display("FAIL hs_pulse: got %b want 10", {hsync_o, vsync_o});
    else n_pass++;
    step();
    n_checks++;
    if ({hsync_o, vsync_o} !== 2'b01) $display("FAIL vs_pulse: got %b want 01", {hsync_o, vsync_o});
    else n_pass++;
    step();
    n_checks++;
    if ({hsync_o, vsync_o} !== 2'b00) $display("FAIL sync_end: got %b want 00", {hsync_o, vsync_o});
    else n_pass++;
  endtask

  // Every index through layer 0 (background = same index, so 8 goes via the background).
  task automatic test_sweep();
    logic [3:0] ii;
    idle();
    video_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ii       = 4'(i);
      layer_px = {4'h8, ii};
      bg_index = ii;
      step();
      step();
      n_checks++;
      if (rgb !== ref_pal[i]) $display("FAIL sweep_idx%0d: got %h want %h", i, rgb, ref_pal[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [13:0] got, want;
    idle();
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      for (int l = 0; l < NL; l++) begin
        layer_px[l*4 +: 4] = ($urandom % 3 == 0) ? 4'd8 : 4'($urandom % 16);
      end
      bg_index = 4'($urandom % 16);
      video_on = ($urandom % 4) != 0;
      hsync    = ($urandom % 5) == 0;
      vsync    = ($urandom % 7) == 0;
      exp_q.push_back(model_out(video_on, layer_px, bg_index, hsync, vsync));
      step();
      if (exp_q.size() == 2) begin
        want = exp_q.pop_front();
        got  = {hsync_o, vsync_o, rgb};
        n_checks++;
        if (got !== want) $display("FAIL random_c%0d: got %h want %h", c, got, want);
        else n_pass++;
      end
    end
    idle();
  endtask

`ifdef PIXEL_COMPOSITOR_PALETTE_WR_EN
  task automatic test_write_frame();
    int accepts;
    idle();
    wr_valid = 1'b1;
    wr_addr  = 4'd2;
    wr_data  = 12'h00F;
    step();
    wr_valid = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL wr_pending_ready: got %b want 0", wr_ready);
    else n_pass++;
    layer_px = 8'h82;
    video_on = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (rgb !== 12'hF00) $display("FAIL wr_before_vblank: got %h want F00", rgb);
    else n_pass++;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL wr_held_ready: got %b want 0", wr_ready);
    else n_pass++;
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    ref_pal[2] = 12'h00F;
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL wr_ready_after_commit: got %b want 1", wr_ready);
    else n_pass++;
    step();
    step();
    n_checks++;
    if (rgb !== 12'h00F) $display("FAIL wr_new_colour: got %h want 00F", rgb);
    else n_pass++;

    // Back-to-back writes during vblank: one accept every other cycle.
    idle();
    vblank   = 1'b1;
    wr_valid = 1'b1;
    accepts  = 0;
    for (int c = 0; c < 10; c++) begin
      wr_addr = 4'(10 + accepts);
      wr_data = 12'($urandom);
      if (wr_ready === 1'b1) begin
        ref_pal[10 + accepts] = wr_data;
        accepts++;
      end
      step();
    end
    wr_valid = 1'b0;
    step();
    vblank = 1'b0;
    n_checks++;
    if (accepts !== 5) $display("FAIL b2b_rate: got %0d accepts want 5", accepts);
    else n_pass++;
    video_on = 1'b1;
    for (int i = 10; i < 15; i++) begin
      layer_px = {4'h8, 4'(i)};
      step();
      step();
      n_checks++;
      if (rgb !== ref_pal[i]) $display("FAIL b2b_entry%0d: got %h want %h", i, rgb, ref_pal[i]);
      else n_pass++;
    end
  endtask

  task automatic test_read_commit_collision();
    logic [11:0] old;
    idle();
    old      = ref_pal[2];
    layer_px = 8'h82;
    video_on = 1'b1;
    vblank   = 1'b1;
    step();
    step();
    step();
    wr_valid = 1'b1;
    wr_addr  = 4'd2;
    wr_data  = 12'hABC;
    step();
    wr_valid = 1'b0;
    n_checks++;
    if (rgb !== old) $display("FAIL coll_accept: got %h want %h", rgb, old);
    else n_pass++;
    step();
    n_checks++;
    if (rgb !== old) $display("FAIL coll_same_cycle: got %h want %h", rgb, old);
    else n_pass++;
    ref_pal[2] = 12'hABC;
    step();
    n_checks++;
    if (rgb !== 12'hABC) $display("FAIL coll_next: got %h want ABC", rgb);
    else n_pass++;
    idle();
  endtask

  task automatic test_reset_pending();
    idle();
    wr_valid = 1'b1;
    wr_addr  = 4'd3;
    wr_data  = 12'h123;
    step();
    wr_valid = 1'b0;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL rstp_pending: got %b want 0", wr_ready);
    else n_pass++;
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 16; i++) ref_pal[i] = DEF_PAL[i];
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL rstp_ready: got %b want 1", wr_ready);
    else n_pass++;
    vblank = 1'b1;
    step();
    step();
    vblank   = 1'b0;
    video_on = 1'b1;
    layer_px = 8'h83;
    step();
    step();
    n_checks++;
    if (rgb !== 12'h0AA) $display("FAIL rstp_discarded: got %h want 0AA", rgb);
    else n_pass++;
    layer_px = 8'h82;
    step();
    step();
    n_checks++;
    if (rgb !== 12'hF00) $display("FAIL rstp_reload: got %h want F00", rgb);
    else n_pass++;
    idle();
  endtask
`else
  task automatic test_no_write();
    int ready_seen;
    idle();
    vblank     = 1'b1;
    wr_valid   = 1'b1;
    ready_seen = 0;
    for (int c = 0; c < 100; c++) begin
      wr_addr = 4'($urandom);
      wr_data = 12'($urandom);
      if (wr_ready !== 1'b0) ready_seen++;
      step();
    end
    n_checks++;
    if (ready_seen !== 0) $display("FAIL nowr_ready: got %0d ready cycles want 0", ready_seen);
    else n_pass++;
    idle();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) ref_pal[i] = DEF_PAL[i];
    RST = 1'b1;
    idle();
    test_reset();
    test_priority();
    test_background();
    test_sync_delay();
    test_sweep();
    test_random();
`ifdef PIXEL_COMPOSITOR_PALETTE_WR_EN
    test_write_frame();
    test_read_commit_collision();
    test_reset_pending();
`else
    test_no_write();
`endif
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
